// File: rtl/alarm_clock_core.sv
// alarm_clock_core: 24h clock with edit FSM, N armable alarms and a ring/snooze controller.
// Latency: pulse inputs act on the next clk edge; outputs are registers or decodes of registers.
// Backpressure: none; every pulse input is consumed on the cycle it is high.
//
// Ports:
//   clk, clr          single clock, synchronous active-high reset
//   en                timekeeping run enable (prescaler held at 0 while low)
//   mode, inc, zero   edit pulses: advance edit state, increment field, clear seconds
//   fmt12             12-hour display select (registered before use)
//   alm_sel, alm_en   alarm being edited, per-alarm arm bits
//   snooze, ack       ring controller pulses
//   hour/min/sec      current time; disp_hour/pm display decode
//   state             edit state; ringing/ring_id/sound ring status
//   edit_hour/min     time of the alarm selected on the previous cycle
module alarm_clock_core #(
  parameter int TICK_DIV   = 100000000,
  parameter int N_ALARMS   = 4,
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_MIN = 5,
  localparam int SEL_W     = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                en,
  input  logic                mode,
  input  logic                inc,
  input  logic                zero,
  input  logic                fmt12,
  input  logic [SEL_W-1:0]    alm_sel,
  input  logic [N_ALARMS-1:0] alm_en,
  input  logic                snooze,
  input  logic                ack,
  output logic [4:0]          hour,
  output logic [5:0]          min,
  output logic [5:0]          sec,
  output logic [4:0]          disp_hour,
  output logic                pm,
  output logic [2:0]          state,
  output logic                ringing,
  output logic [2:0]          ring_id,
  output logic                sound,
  output logic [4:0]          edit_hour,
  output logic [5:0]          edit_min
);

  localparam int PW        = $clog2(TICK_DIV);
  localparam int SNZ_TICKS = SNOOZE_MIN * 60;
  localparam int RW        = (RING_SEC < 1) ? 1 : $clog2(RING_SEC + 1);
  localparam int SW        = (SNZ_TICKS < 1) ? 1 : $clog2(SNZ_TICKS + 1);

  localparam logic [PW-1:0] PRESC_MAX  = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRESC_HALF = PW'(TICK_DIV / 2);
  localparam logic [RW-1:0] RING_LOAD  = RW'(RING_SEC);
  localparam logic [SW-1:0] SNZ_LOAD   = SW'(SNZ_TICKS);

  typedef struct packed {
    logic [4:0] hour;
    logic [5:0] min;
  } alm_t;

  typedef enum logic [2:0] {
    E_RUN   = 3'd0,
    E_HOUR  = 3'd1,
    E_MIN   = 3'd2,
    E_SEC   = 3'd3,
    E_AHOUR = 3'd4,
    E_AMIN  = 3'd5
  } estate_t;

  typedef enum logic [1:0] {
    R_IDLE    = 2'd0,
    R_RING    = 2'd1,
    R_SNOOZED = 2'd2
  } rstate_t;

  logic [PW-1:0]    presc;
  logic             tick;
  estate_t          est, est_nx;
  rstate_t          ring_st, ring_st_nx;
  logic [RW-1:0]    ring_cnt, ring_cnt_nx;
  logic [SW-1:0]    snz_cnt, snz_cnt_nx;
  logic [2:0]       ring_id_nx;
  alm_t             alarms [N_ALARMS];
  logic [SEL_W-1:0] sel_q;
  logic             fmt12_q;

  logic             run_st;
  logic             time_tick;
  logic             roll;
  logic             sec_wrap, min_wrap;
  logic [5:0]       sec_tk, min_tk;
  logic [4:0]       hour_tk;
  logic             hit;
  logic [2:0]       hit_id;
  logic             match;

  // zero suppresses a coincident tick entirely, so neither time nor ring counters see it
  assign tick      = en && !zero && (presc == PRESC_MAX);
  assign run_st    = (est == E_RUN) || (est == E_AHOUR) || (est == E_AMIN);
  assign time_tick = tick && run_st;

  // Time after one running tick, with full carry chain
  always_comb begin
    sec_wrap = (sec == 6'd59);
    min_wrap = (min == 6'd59);
    sec_tk   = sec_wrap ? 6'd0 : sec + 6'd1;
    min_tk   = sec_wrap ? (min_wrap ? 6'd0 : min + 6'd1) : min;
    hour_tk  = (sec_wrap && min_wrap) ? ((hour == 5'd23) ? 5'd0 : hour + 5'd1) : hour;
  end

  assign roll = time_tick && sec_wrap;

  // Descending scan so the lowest matching index is the last one written
  always_comb begin
    hit    = 1'b0;
    hit_id = 3'd0;
    for (int k = N_ALARMS - 1; k >= 0; k--) begin
      if (alm_en[k] && (alarms[k].hour == hour_tk) && (alarms[k].min == min_tk)) begin
        hit    = 1'b1;
        hit_id = 3'(k);
      end
    end
  end

  assign match = roll && hit;

  // Edit state next-state
  always_comb begin
    est_nx = est;
    if (mode) begin
      case (est)
        E_RUN:   est_nx = E_HOUR;
        E_HOUR:  est_nx = E_MIN;
        E_MIN:   est_nx = E_SEC;
        E_SEC:   est_nx = E_AHOUR;
        E_AHOUR: est_nx = E_AMIN;
        default: est_nx = E_RUN;
      endcase
    end
  end

  // Ring controller next-state; ack has priority over snooze and over counter expiry
  always_comb begin
    ring_st_nx  = ring_st;
    ring_cnt_nx = ring_cnt;
    snz_cnt_nx  = snz_cnt;
    ring_id_nx  = ring_id;
    case (ring_st)
      R_IDLE: begin
        if (match) begin
          ring_st_nx  = R_RING;
          ring_cnt_nx = RING_LOAD;
          ring_id_nx  = hit_id;
        end
      end
      R_RING: begin
        if (ack) begin
          ring_st_nx = R_IDLE;
        end else if (snooze) begin
          ring_st_nx = R_SNOOZED;
          snz_cnt_nx = SNZ_LOAD;
        end else if (tick) begin
          if (ring_cnt <= RW'(1)) begin
            ring_cnt_nx = '0;
            ring_st_nx  = R_IDLE;
          end else begin
            ring_cnt_nx = ring_cnt - RW'(1);
          end
        end
      end
      R_SNOOZED: begin
        if (ack) begin
          ring_st_nx = R_IDLE;
        end else if (tick) begin
          if (snz_cnt <= SW'(1)) begin
            snz_cnt_nx  = '0;
            ring_st_nx  = R_RING;
            ring_cnt_nx = RING_LOAD;
          end else begin
            snz_cnt_nx = snz_cnt - SW'(1);
          end
        end
      end
      default: ring_st_nx = R_IDLE;
    endcase
  end

  // FSM state registers
  always_ff @(posedge clk) begin
    if (clr) begin
      est      <= E_RUN;
      ring_st  <= R_IDLE;
      ring_cnt <= '0;
      snz_cnt  <= '0;
      ring_id  <= 3'd0;
    end else begin
      est      <= est_nx;
      ring_st  <= ring_st_nx;
      ring_cnt <= ring_cnt_nx;
      snz_cnt  <= snz_cnt_nx;
      ring_id  <= ring_id_nx;
    end
  end

  // Prescaler, time and alarm storage
  always_ff @(posedge clk) begin
    // Registered so display and edit readback never see an input combinationally
    fmt12_q <= fmt12;
    sel_q   <= alm_sel;
    if (clr) begin
      presc <= '0;
      hour  <= 5'd0;
      min   <= 6'd0;
      sec   <= 6'd0;
      for (int k = 0; k < N_ALARMS; k++) begin
        alarms[k] <= '0;
      end
    end else begin
      if (zero || !en || (presc == PRESC_MAX)) begin
        presc <= '0;
      end else begin
        presc <= presc + PW'(1);
      end

      if (time_tick) begin
        sec  <= sec_tk;
        min  <= min_tk;
        hour <= hour_tk;
      end

      // Time field edits only happen in frozen states, so they never collide with time_tick
      if (inc) begin
        case (est)
          E_HOUR:  hour <= (hour == 5'd23) ? 5'd0 : hour + 5'd1;
          E_MIN:   min  <= (min == 6'd59) ? 6'd0 : min + 6'd1;
          E_SEC:   sec  <= (sec == 6'd59) ? 6'd0 : sec + 6'd1;
          default: ;
        endcase
      end

      // Out-of-range alm_sel matches no k, so the inc is dropped
      for (int k = 0; k < N_ALARMS; k++) begin
        if (inc && (alm_sel == SEL_W'(k))) begin
          if (est == E_AHOUR) begin
            alarms[k].hour <= (alarms[k].hour == 5'd23) ? 5'd0 : alarms[k].hour + 5'd1;
          end else if (est == E_AMIN) begin
            alarms[k].min <= (alarms[k].min == 6'd59) ? 6'd0 : alarms[k].min + 6'd1;
          end
        end
      end

      // Last assignment: zero overrides both tick and sec edit
      if (zero) begin
        sec <= 6'd0;
      end
    end
  end

  // Output decodes
  assign state   = est;
  assign ringing = (ring_st == R_RING);
  assign sound   = ringing && (presc < PRESC_HALF);
  assign pm      = (hour >= 5'd12);

  always_comb begin
    disp_hour = hour;
    if (fmt12_q) begin
      if (hour == 5'd0) begin
        disp_hour = 5'd12;
      end else if (hour > 5'd12) begin
        disp_hour = hour - 5'd12;
      end
    end
  end

  always_comb begin
    edit_hour = 5'd0;
    edit_min  = 6'd0;
    for (int k = 0; k < N_ALARMS; k++) begin
      if (sel_q == SEL_W'(k)) begin
        edit_hour = alarms[k].hour;
        edit_min  = alarms[k].min;
      end
    end
  end

endmodule
